// File: rtl/fizzbuzz_pkg.sv
// Shared types and helpers for the multi-channel fizz/buzz tick generator.
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest packed divisor-init vector the helper accepts.
  localparam int unsigned InitVecW = 256;

  // Slice i of a packed divisor vector, channel 0 in the LSBs.
  function automatic int unsigned div_init(input logic [InitVecW-1:0] init,
                                           input int unsigned div_w,
                                           input int unsigned i);
    logic [InitVecW-1:0] sh;
    sh = init >> (i * div_w);
    return 32'(sh) & ((32'd1 << div_w) - 32'd1);
  endfunction

endpackage

// File: rtl/mod_residue_ctr.sv
// Tracks count mod div by stepping a residue alongside the main counter.
module mod_residue_ctr #(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             step,
  input  logic             wrap_clr,
  input  logic [DIV_W-1:0] div,
  output logic [DIV_W-1:0] residue,
  output logic             is_zero
);

  logic [DIV_W-1:0] residue_q, residue_d;

  always_comb begin
    residue_d = residue_q;
    if (clr) begin
      residue_d = '0;
    end else if (step) begin
      // Main counter wrapping forces realignment so residue == count mod div.
      if (residue_q == div - DIV_W'(1) || wrap_clr) begin
        residue_d = '0;
      end else begin
        residue_d = residue_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      residue_q <= '0;
    end else begin
      residue_q <= residue_d;
    end
  end

  assign residue = residue_q;
  assign is_zero = (residue_q == '0);

endmodule

// File: rtl/fizzbuzz_multi.sv
// Cycle counter with N_DIV programmable divisibility channels and a start/stop controller.
module fizzbuzz_multi
  import fizzbuzz_pkg::*;
#(
  parameter int unsigned N_DIV      = 2,
  parameter int unsigned DIV_W      = 4,
  parameter int unsigned MAX_CYCLES = 100,
  parameter int unsigned CNT_W      = $clog2(MAX_CYCLES),
  parameter int unsigned IDX_W      = (N_DIV > 1) ? $clog2(N_DIV) : 1,
  parameter logic [N_DIV*DIV_W-1:0] DIV_INIT = {4'd5, 4'd3}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_err,
  output logic [CNT_W-1:0] count,
  output logic [N_DIV-1:0] hit,
  output logic             all_hit,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             cfg_err_q, cfg_err_d;

  logic             at_last;
  logic             step;
  logic             idx_ok;
  logic             cfg_ok;
  logic [N_DIV-1:0] div_nz;
  logic [N_DIV-1:0] is_zero;

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign at_last = (count_q == CNT_W'(MAX_CYCLES - 1));
  assign step    = busy & en & ~start & ~stop;
  assign idx_ok  = (32'(cfg_idx) < N_DIV);
  assign cfg_ok  = cfg_we & ~busy & idx_ok;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mode_d    = mode_q;
    wrap_d    = 1'b0;
    cfg_err_d = cfg_we & (busy | ~idx_ok);
    if (start) begin
      state_d = RUN;
      count_d = '0;
      mode_d  = oneshot;
    end else if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (step) begin
      if (at_last) begin
        count_d = '0;
        if (mode_q) begin
          state_d = DONE;
        end else begin
          wrap_d = 1'b1;
        end
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mode_q    <= 1'b0;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < N_DIV; i++) begin : g_ch
    localparam logic [DIV_W-1:0] InitDiv =
        DIV_W'(div_init(InitVecW'(DIV_INIT), DIV_W, i));

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] unused_residue;
    logic             wr_en;

    assign wr_en = cfg_ok & (cfg_idx == IDX_W'(i));

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        div_q <= InitDiv;
      end else if (wr_en) begin
        div_q <= cfg_div;
      end
    end

    mod_residue_ctr #(
      .DIV_W(DIV_W)
    ) u_ctr (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (start | stop | wr_en),
      .step    (step),
      .wrap_clr(at_last),
      .div     (div_q),
      .residue (unused_residue),
      .is_zero (is_zero[i])
    );

    assign div_nz[i] = (div_q != '0);
    assign hit[i]    = busy & div_nz[i] & is_zero[i];
  end

  // Disabled channels count as satisfied, but at least one must be enabled.
  assign all_hit = busy & (|div_nz) & (&(hit | ~div_nz));
  assign count   = count_q;
  assign wrap    = wrap_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_fizzbuzz_multi.sv
// Directed self-checking bench for fizzbuzz_multi (default instance plus a 3-channel one).
module tb_fizzbuzz_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       start, stop, oneshot, en, cfg_we;
  logic [0:0] cfg_idx;
  logic [3:0] cfg_div;
  logic       cfg_err, all_hit, wrap, busy, done;
  logic [6:0] count;
  logic [1:0] hit;

  logic       start3, stop3, oneshot3, en3, cfg_we3;
  logic [1:0] cfg_idx3;
  logic [3:0] cfg_div3;
  logic       cfg_err3, all_hit3, wrap3, busy3, done3;
  logic [6:0] count3;
  logic [2:0] hit3;

  int n_cmp = 0;
  int n_bad = 0;

  fizzbuzz_multi u_dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop), .oneshot(oneshot), .en(en),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_div(cfg_div), .cfg_err(cfg_err), .count(count),
    .hit(hit), .all_hit(all_hit), .wrap(wrap), .busy(busy), .done(done)
  );

  fizzbuzz_multi #(
    .N_DIV(3), .DIV_W(4), .MAX_CYCLES(100), .DIV_INIT(12'h753)
  ) u_dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .stop(stop3), .oneshot(oneshot3), .en(en3),
    .cfg_we(cfg_we3), .cfg_idx(cfg_idx3), .cfg_div(cfg_div3), .cfg_err(cfg_err3),
    .count(count3), .hit(hit3), .all_hit(all_hit3), .wrap(wrap3), .busy(busy3), .done(done3)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [13:0] obs;
    resetn = 1'b0;
    start = 0; stop = 0; oneshot = 0; en = 1; cfg_we = 0; cfg_idx = '0; cfg_div = '0;
    start3 = 0; stop3 = 0; oneshot3 = 0; en3 = 1; cfg_we3 = 0; cfg_idx3 = '0; cfg_div3 = '0;
    tick; tick;
    obs = {count, hit, all_hit, wrap, busy, done, cfg_err};
    if (obs !== 14'd0) begin
      $display("FAIL reset_outputs: got %h want 0", obs); n_bad++;
    end
    n_cmp++;
    resetn = 1'b1;
    tick;
    obs = {count, hit, all_hit, wrap, busy, done, cfg_err};
    if (obs !== 14'd0) begin
      $display("FAIL idle_outputs: got %h want 0", obs); n_bad++;
    end
    n_cmp++;
    if ({count3, hit3, busy3, done3} !== 12'd0) begin
      $display("FAIL reset_dut3: got %h want 0", {count3, hit3, busy3, done3}); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_wrap_mode;
    logic [1:0] exp_hit;
    start = 1; oneshot = 0; en = 1;
    tick;
    start = 0;
    for (int c = 0; c < 100; c++) begin
      exp_hit = {c % 5 == 0, c % 3 == 0};
      if (count !== 7'(c)) begin
        $display("FAIL wrap_count: got %0d want %0d", count, c); n_bad++;
      end
      n_cmp++;
      if (hit !== exp_hit) begin
        $display("FAIL wrap_hit c=%0d: got %b want %b", c, hit, exp_hit); n_bad++;
      end
      n_cmp++;
      if (all_hit !== (c % 15 == 0)) begin
        $display("FAIL wrap_all_hit c=%0d: got %b want %b", c, all_hit, c % 15 == 0); n_bad++;
      end
      n_cmp++;
      if (wrap !== 1'b0) begin
        $display("FAIL wrap_idle c=%0d: got %b want 0", c, wrap); n_bad++;
      end
      n_cmp++;
      tick;
    end
    if ({count, wrap, hit, all_hit, busy} !== {7'd0, 1'b1, 2'b11, 1'b1, 1'b1}) begin
      $display("FAIL wrap_pulse: got %0d/%b/%b/%b/%b want 0/1/11/1/1",
               count, wrap, hit, all_hit, busy); n_bad++;
    end
    n_cmp++;
    tick;
    if ({count, wrap} !== {7'd1, 1'b0}) begin
      $display("FAIL wrap_after: got %0d/%b want 1/0", count, wrap); n_bad++;
    end
    n_cmp++;
    stop = 1;
    tick;
    stop = 0;
    if ({busy, count, hit} !== 10'd0) begin
      $display("FAIL stop_idle: got %b/%0d/%b want 0/0/00", busy, count, hit); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_oneshot;
    start = 1; oneshot = 1;
    tick;
    start = 0; oneshot = 0;
    for (int c = 0; c < 100; c++) begin
      if ({count, busy, done} !== {7'(c), 1'b1, 1'b0}) begin
        $display("FAIL oneshot_run c=%0d: got %0d/%b/%b", c, count, busy, done); n_bad++;
      end
      n_cmp++;
      tick;
    end
    for (int k = 0; k < 2; k++) begin
      if ({done, busy, count, hit, all_hit, wrap} !== {1'b1, 1'b0, 7'd0, 2'b00, 1'b0, 1'b0}) begin
        $display("FAIL oneshot_done k=%0d: got done=%b busy=%b cnt=%0d hit=%b all=%b wrap=%b",
                 k, done, busy, count, hit, all_hit, wrap); n_bad++;
      end
      n_cmp++;
      tick;
    end
    start = 1;
    tick;
    start = 0;
    if ({busy, done, count, hit} !== {1'b1, 1'b0, 7'd0, 2'b11}) begin
      $display("FAIL oneshot_restart: got %b/%b/%0d/%b want 1/0/0/11", busy, done, count, hit);
      n_bad++;
    end
    n_cmp++;
    stop = 1;
    tick;
    stop = 0;
  endtask

  task automatic test_pause;
    start = 1;
    tick;
    start = 0;
    repeat (7) tick;
    en = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      if ({count, hit} !== {7'd7, 2'b00}) begin
        $display("FAIL pause_hold k=%0d: got %0d/%b want 7/00", k, count, hit); n_bad++;
      end
      n_cmp++;
    end
    en = 1;
    tick;
    if ({count, hit} !== {7'd8, 2'b00}) begin
      $display("FAIL pause_resume8: got %0d/%b want 8/00", count, hit); n_bad++;
    end
    n_cmp++;
    tick;
    if ({count, hit} !== {7'd9, 2'b01}) begin
      $display("FAIL pause_resume9: got %0d/%b want 9/01", count, hit); n_bad++;
    end
    n_cmp++;
    tick;
    if ({count, hit} !== {7'd10, 2'b10}) begin
      $display("FAIL pause_resume10: got %0d/%b want 10/10", count, hit); n_bad++;
    end
    n_cmp++;
    stop = 1;
    tick;
    stop = 0;
  endtask

  task automatic test_reprogram;
    logic [1:0] exp_hit;
    cfg_we = 1; cfg_idx = 1'b1; cfg_div = 4'd7;
    tick;
    cfg_idx = 1'b0; cfg_div = 4'd0;
    if (cfg_err !== 1'b0) begin
      $display("FAIL cfg_idle_err1: got %b want 0", cfg_err); n_bad++;
    end
    n_cmp++;
    tick;
    cfg_we = 0;
    if (cfg_err !== 1'b0) begin
      $display("FAIL cfg_idle_err0: got %b want 0", cfg_err); n_bad++;
    end
    n_cmp++;
    start = 1;
    tick;
    start = 0;
    for (int c = 0; c < 100; c++) begin
      exp_hit = {c % 7 == 0, 1'b0};
      if ({hit, all_hit} !== {exp_hit, c % 7 == 0}) begin
        $display("FAIL reprog_hit c=%0d: got %b/%b want %b/%b", c, hit, all_hit, exp_hit,
                 c % 7 == 0); n_bad++;
      end
      n_cmp++;
      tick;
    end
    if ({count, hit, wrap} !== {7'd0, 2'b10, 1'b1}) begin
      $display("FAIL reprog_wrap: got %0d/%b/%b want 0/10/1", count, hit, wrap); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_cfg_err;
    cfg_we = 1; cfg_idx = 1'b0; cfg_div = 4'd1;
    tick;
    cfg_we = 0;
    if ({cfg_err, count, hit[0]} !== {1'b1, 7'd1, 1'b0}) begin
      $display("FAIL run_write_err: got %b/%0d/%b want 1/1/0", cfg_err, count, hit[0]); n_bad++;
    end
    n_cmp++;
    tick;
    if ({cfg_err, hit[0]} !== 2'b00) begin
      $display("FAIL run_write_pulse: got %b/%b want 0/0", cfg_err, hit[0]); n_bad++;
    end
    n_cmp++;
    stop = 1;
    tick;
    stop = 0;
    cfg_we = 1; cfg_idx = 1'b0; cfg_div = 4'd1; start = 1;
    tick;
    cfg_we = 0; start = 0;
    if (cfg_err !== 1'b0) begin
      $display("FAIL start_write_err: got %b want 0", cfg_err); n_bad++;
    end
    n_cmp++;
    for (int c = 0; c < 42; c++) begin
      if ({hit, all_hit} !== {c % 7 == 0, 1'b1, c % 7 == 0}) begin
        $display("FAIL div1_hit c=%0d: got %b/%b want %b1/%b", c, hit, all_hit, c % 7 == 0,
                 c % 7 == 0); n_bad++;
      end
      n_cmp++;
      tick;
    end
  endtask

  task automatic test_reset_mid;
    if ({count, hit} !== {7'd42, 2'b11}) begin
      $display("FAIL mid_pre: got %0d/%b want 42/11", count, hit); n_bad++;
    end
    n_cmp++;
    #2 resetn = 1'b0;
    #1;
    if ({count, hit, all_hit, wrap, busy, done, cfg_err} !== 14'd0) begin
      $display("FAIL mid_reset_async: got %0d/%b/%b/%b/%b/%b/%b want all 0",
               count, hit, all_hit, wrap, busy, done, cfg_err); n_bad++;
    end
    n_cmp++;
    tick;
    resetn = 1'b1;
    start = 1; stop = 1;
    tick;
    start = 0; stop = 0;
    if ({busy, count, hit} !== {1'b1, 7'd0, 2'b11}) begin
      $display("FAIL start_stop_same: got %b/%0d/%b want 1/0/11", busy, count, hit); n_bad++;
    end
    n_cmp++;
    repeat (3) tick;
    if ({count, hit} !== {7'd3, 2'b01}) begin
      $display("FAIL restored_div3: got %0d/%b want 3/01", count, hit); n_bad++;
    end
    n_cmp++;
    repeat (2) tick;
    if ({count, hit} !== {7'd5, 2'b10}) begin
      $display("FAIL restored_div5: got %0d/%b want 5/10", count, hit); n_bad++;
    end
    n_cmp++;
    stop = 1;
    tick;
    stop = 0;
  endtask

  task automatic test_idx_range;
    cfg_we3 = 1; cfg_idx3 = 2'd3; cfg_div3 = 4'd2;
    tick;
    cfg_we3 = 0;
    if (cfg_err3 !== 1'b1) begin
      $display("FAIL idx_oob_err: got %b want 1", cfg_err3); n_bad++;
    end
    n_cmp++;
    tick;
    if (cfg_err3 !== 1'b0) begin
      $display("FAIL idx_oob_pulse: got %b want 0", cfg_err3); n_bad++;
    end
    n_cmp++;
    start3 = 1;
    tick;
    start3 = 0;
    for (int c = 0; c < 22; c++) begin
      if ({hit3, all_hit3} !== {c % 7 == 0, c % 5 == 0, c % 3 == 0, c % 105 == 0}) begin
        $display("FAIL idx_oob_divs c=%0d: got %b/%b", c, hit3, all_hit3); n_bad++;
      end
      n_cmp++;
      tick;
    end
    stop3 = 1;
    tick;
    stop3 = 0;
  endtask

  initial begin
    test_reset();
    test_wrap_mode();
    test_oneshot();
    test_pause();
    test_reprogram();
    test_cfg_err();
    test_reset_mid();
    test_idx_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
